cookie_grid: RTL and testbench
==============================

// Module: cookie_grid
// PURPOSE
//  Parametrised cellular-automaton array: COLS x ROWS one-bit cells, Moore (8-neighbour) rule set by masks.
//  Serial load chain writes the grid. Step/run advance every cell in one cycle.
//  A snapshot-buffered display stream reads the grid out with a valid/ready handshake.
//  Successor to the fixed 16x16 crumb array; feeds the tile's serial I/O shim.
// PARAMETERS
//  COLS          16            grid width, >=3
//  ROWS          16            grid height, >=3
//  BIRTH_MASK    9'b000001000  bit n set: dead cell with n live neighbours is born (default B3)
//  SURVIVE_MASK  9'b000001100  bit n set: live cell with n live neighbours survives (default S23)
//  GEN_W         16            generation counter width
// PORTS
//  clk         in   1      single clock, all logic on rising edge
//  rst         in   1      synchronous, active-high reset
//  en          in   1      global enable; low = every register holds, inputs ignored
//  load_valid  in   1      shift load_bit into cell 0 this cycle
//  load_bit    in   1      serial grid data
//  step        in   1      pulse: compute one generation
//  run         in   1      level: compute one generation every enabled cycle
//  disp_start  in   1      pulse: snapshot grid, begin stream
//  disp_ready  in   1      sink accepts disp_bit
//  disp_valid  out  1      disp_bit valid
//  disp_bit    out  1      snapshot cell, index 0 first
//  disp_last   out  1      high with final bit (index N-1)
//  disp_busy   out  1      stream in progress
//  gen_count   out  GEN_W  generations since reset/load
//  extinct     out  1      all cells dead after last generation
//  stable      out  1      last generation equal to its predecessor
// BEHAVIOUR
//  N = COLS*ROWS; cell index = row*COLS + col; neighbour count 4-bit, range 0..8.
//  Reset: grid all 0, snapshot all 0, gen_count 0, disp_valid/disp_last/disp_busy 0, extinct 0, stable 0.
//  Load (en & load_valid): cell[0]<=load_bit, cell[k]<=cell[k-1]. After N loads, first bit sits in cell N-1.
//    Each load clears gen_count, extinct, stable. No ready signal: load is always accepted when en.
//  Generation (en & (step|run) & !load_valid):
//    next = cell ? SURVIVE_MASK[cnt] : BIRTH_MASK[cnt]; all cells update together, 1-cycle latency.
//    gen_count+1, wrapping at 2^GEN_W. extinct <= (next==0). stable <= (next==cell).
//  Collision: load_valid with step/run -> load wins; the generation is dropped, not queued.
//  Edge cells: neighbours outside the grid read 0 (see CONFIGURATION).
//  Display FSM, states IDLE -> STREAM -> IDLE:
//    IDLE & en & disp_start: snapshot<=grid, ptr<=0, disp_busy=1, disp_valid=1 next cycle.
//    STREAM: disp_bit=snapshot[ptr]; disp_valid&disp_ready&en -> ptr+1.
//    disp_last = disp_valid & (ptr==N-1). Transfer of last bit -> IDLE, valid/busy 0 next cycle.
//    disp_start in STREAM is ignored. disp_bit holds stable while valid & !ready.
//    Grid load/step continue during STREAM; the stream shows the snapshot only.
//  rst mid-stream aborts it: disp_valid 0 next cycle, no disp_last; grid cleared.
//  en low mid-stream: ptr and outputs hold; disp_valid stays asserted.
// CONFIGURATION
//  COOKIE_TORUS_EN defined: neighbour coords wrap modulo COLS/ROWS (toroidal grid).
//  Undefined: zero border as above. Macro does not change ports or latency.
// TESTING
//  1 Blinker: load row 1 cols 0..2 of a 3x3 in a 16x16, step -> column 1 rows 0..2; step -> original;
//    gen_count=2; stable=0.
//  2 Block 2x2 at (5,5), step x3 -> grid unchanged, stable=1, extinct=0, gen_count=3.
//  3 Single live cell, step -> grid 0, extinct=1. Same cycle load_valid&step -> only load applied,
//    gen_count=0.
//  4 Dump with disp_ready toggling 1010..: exactly N transfers in index order.
//    disp_last only on transfer N; run=1 during dump does not alter the streamed bits.
//  5 Glider heading +x,+y, 64 steps on 16x16: with COOKIE_TORUS_EN, returns to start pattern.
//    Without it, it settles to a 2x2 block at the corner.
//  6 rst at bit 100 of a dump -> disp_valid=0 and grid/gen_count=0 next cycle; new disp_start streams N zeros.

Source files
------------

// File: rtl/cookie_grid.sv
// cookie_grid: COLS x ROWS Moore-neighbourhood cellular automaton with a serial load chain and a snapshot display stream.
// Optional macro COOKIE_TORUS_EN wraps neighbour coordinates (toroidal grid); otherwise cells beyond the border read dead.
module cookie_grid #(
  parameter int unsigned COLS         = 16,
  parameter int unsigned ROWS         = 16,
  parameter logic [8:0]  BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0]  SURVIVE_MASK = 9'b000001100,
  parameter int unsigned GEN_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_valid,
  input  logic             load_bit,
  input  logic             step,
  input  logic             run,
  input  logic             disp_start,
  input  logic             disp_ready,
  output logic             disp_valid,
  output logic             disp_bit,
  output logic             disp_last,
  output logic             disp_busy,
  output logic [GEN_W-1:0] gen_count,
  output logic             extinct,
  output logic             stable
);

  localparam int unsigned N     = COLS * ROWS;
  localparam int unsigned IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {ST_IDLE, ST_STREAM} disp_state_e;

  logic [N-1:0]     grid_q, grid_d, nxt_grid;
  logic [N-1:0]     snap_q, snap_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             extinct_q, extinct_d;
  logic             stable_q, stable_d;
  disp_state_e      state_q, state_d;
  logic             disp_valid_q, disp_valid_d;
  logic             disp_bit_q, disp_bit_d;
  logic             disp_last_q, disp_last_d;
  logic             disp_busy_q, disp_busy_d;

  // Neighbour lookup; coordinates may be one step outside the grid.
  function automatic logic cell_at(input logic [N-1:0] g, input int r, input int c);
    int   rr;
    int   cc;
    logic in_grid;
`ifdef COOKIE_TORUS_EN
    in_grid = 1'b1;
    rr      = (r + int'(ROWS)) % int'(ROWS);
    cc      = (c + int'(COLS)) % int'(COLS);
`else
    in_grid = (r >= 0) && (r < int'(ROWS)) && (c >= 0) && (c < int'(COLS));
    rr      = in_grid ? r : 0;
    cc      = in_grid ? c : 0;
`endif
    return in_grid & g[IDX_W'(rr * int'(COLS) + cc)];
  endfunction

  // Next generation for every cell from the current grid.
  always_comb begin
    logic [3:0] cnt;
    cnt      = '0;
    nxt_grid = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c < int'(COLS); c++) begin
        cnt = '0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) cnt = cnt + 4'(cell_at(grid_q, r + dr, c + dc));
          end
        end
        nxt_grid[IDX_W'(r * int'(COLS) + c)] = grid_q[IDX_W'(r * int'(COLS) + c)] ?
                                               SURVIVE_MASK[cnt] : BIRTH_MASK[cnt];
      end
    end
  end

  // Load chain, generation update and display FSM next state.
  always_comb begin
    grid_d    = grid_q;
    gen_d     = gen_q;
    extinct_d = extinct_q;
    stable_d  = stable_q;
    snap_d    = snap_q;
    ptr_d     = ptr_q;
    state_d   = state_q;

    if (en) begin
      if (load_valid) begin
        grid_d    = {grid_q[N-2:0], load_bit};
        gen_d     = '0;
        extinct_d = 1'b0;
        stable_d  = 1'b0;
      end else if (step || run) begin
        grid_d    = nxt_grid;
        gen_d     = gen_q + GEN_W'(1);
        extinct_d = (nxt_grid == '0);
        stable_d  = (nxt_grid == grid_q);
      end

      case (state_q)
        ST_IDLE: begin
          if (disp_start) begin
            snap_d  = grid_q;
            ptr_d   = '0;
            state_d = ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (disp_ready) begin
            if (ptr_q == LAST_IDX) state_d = ST_IDLE;
            else                   ptr_d   = ptr_q + IDX_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    disp_valid_d = (state_d == ST_STREAM);
    disp_busy_d  = (state_d == ST_STREAM);
    disp_bit_d   = snap_d[ptr_d];
    disp_last_d  = (state_d == ST_STREAM) && (ptr_d == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grid_q       <= '0;
      snap_q       <= '0;
      ptr_q        <= '0;
      gen_q        <= '0;
      extinct_q    <= 1'b0;
      stable_q     <= 1'b0;
      state_q      <= ST_IDLE;
      disp_valid_q <= 1'b0;
      disp_bit_q   <= 1'b0;
      disp_last_q  <= 1'b0;
      disp_busy_q  <= 1'b0;
    end else begin
      grid_q       <= grid_d;
      snap_q       <= snap_d;
      ptr_q        <= ptr_d;
      gen_q        <= gen_d;
      extinct_q    <= extinct_d;
      stable_q     <= stable_d;
      state_q      <= state_d;
      disp_valid_q <= disp_valid_d;
      disp_bit_q   <= disp_bit_d;
      disp_last_q  <= disp_last_d;
      disp_busy_q  <= disp_busy_d;
    end
  end

  assign disp_valid = disp_valid_q;
  assign disp_bit   = disp_bit_q;
  assign disp_last  = disp_last_q;
  assign disp_busy  = disp_busy_q;
  assign gen_count  = gen_q;
  assign extinct    = extinct_q;
  assign stable     = stable_q;

endmodule

// File: tb/tb_cookie_grid.sv
// tb_cookie_grid: randomized checks of cookie_grid against a B3/S23 life model kept in the bench.
module tb_cookie_grid;

  localparam int COLS  = 16;
  localparam int ROWS  = 16;
  localparam int N     = COLS * ROWS;
  localparam int GEN_M = 65536;

  typedef bit grid_t [N];

  logic        clk = 1'b0;
  logic        rst, en, load_valid, load_bit, step, run, disp_start, disp_ready;
  logic        disp_valid, disp_bit, disp_last, disp_busy, extinct, stable;
  logic [15:0] gen_count;

  int    vectors     = 0;
  int    miscompares = 0;
  grid_t mdl;
  int    mgen;
  bit    mext, mstab;

  cookie_grid #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .load_bit(load_bit),
    .step(step), .run(run), .disp_start(disp_start), .disp_ready(disp_ready),
    .disp_valid(disp_valid), .disp_bit(disp_bit), .disp_last(disp_last), .disp_busy(disp_busy),
    .gen_count(gen_count), .extinct(extinct), .stable(stable)
  );

  always #5 clk = ~clk;

  // Life rule: born with exactly 3 neighbours, survives with 2 or 3.
  function automatic void life(input grid_t g, output grid_t n);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
`ifdef COOKIE_TORUS_EN
            rr = (rr + ROWS) % ROWS;
            cc = (cc + COLS) % COLS;
`else
            if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) continue;
`endif
            cnt += int'(g[rr * COLS + cc]);
          end
        end
        n[r * COLS + c] = g[r * COLS + c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
      end
    end
  endfunction

  task automatic model_step();
    grid_t n;
    bit same, dead;
    life(mdl, n);
    same = 1'b1;
    dead = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (n[i] != mdl[i]) same = 1'b0;
      if (n[i]) dead = 1'b0;
    end
    mdl   = n;
    mext  = dead;
    mstab = same;
    mgen  = (mgen + 1) % GEN_M;
  endtask

  function automatic void clear_pat(output grid_t p);
    for (int i = 0; i < N; i++) p[i] = 1'b0;
  endfunction

  function automatic void rand_pat(output grid_t p, input int pct);
    for (int i = 0; i < N; i++) p[i] = ($urandom_range(0, 99) < pct);
  endfunction

  // Serial load: the first bit shifted in ends up in cell N-1.
  task automatic load_grid(input grid_t p);
    for (int k = 0; k < N; k++) begin
      load_valid = 1'b1;
      load_bit   = p[N-1-k];
      @(negedge clk);
    end
    load_valid = 1'b0;
    mdl   = p;
    mgen  = 0;
    mext  = 1'b0;
    mstab = 1'b0;
  endtask

  task automatic do_steps(input int n);
    step = 1'b1;
    repeat (n) @(negedge clk);
    step = 1'b0;
    repeat (n) model_step();
  endtask

  // Collect one display stream. mode 0: ready always, 1: ready 1010.., 2: random ready.
  task automatic capture(input int mode, input bit run_during, input bit en_rand,
                         output grid_t cap, output int nx, output int nlast, output int lastpos,
                         output int holdbad, output int steps);
    bit tog, prev_hold, prev_bit, r, e, xfer;
    nx = 0; nlast = 0; lastpos = -1; holdbad = 0; steps = 0;
    tog = 1'b1; prev_hold = 1'b0; prev_bit = 1'b0;
    for (int i = 0; i < N; i++) cap[i] = 1'b0;
    en = 1'b1;
    disp_start = 1'b1;
    run = run_during;
    if (run_during) steps++;
    @(negedge clk);
    disp_start = 1'b0;
    for (int cyc = 0; cyc < 8 * N && nx < N; cyc++) begin
      if (prev_hold && (!disp_valid || disp_bit !== prev_bit)) holdbad++;
      case (mode)
        0:       r = 1'b1;
        1:       begin r = tog; tog = ~tog; end
        default: r = 1'($urandom_range(0, 1));
      endcase
      e = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      xfer = disp_valid && r && e;
      if (xfer) begin
        cap[nx] = disp_bit;
        if (disp_last) begin nlast++; lastpos = nx; end
        nx++;
      end
      prev_hold  = disp_valid && !xfer;
      prev_bit   = disp_bit;
      disp_ready = r;
      en         = e;
      disp_start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      run        = run_during && (nx < N);
      if (run_during && e && nx < N) steps++;
      @(negedge clk);
    end
    disp_ready = 1'b0;
    disp_start = 1'b0;
    en         = 1'b1;
    run        = 1'b0;
  endtask

  task automatic test_reset();
    grid_t cap, z;
    int nx, nlast, lastpos, holdbad, steps, bad;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if ({disp_valid, disp_last, disp_busy} !== 3'b000) begin miscompares++; $display("FAIL reset_disp got v/l/b=%b%b%b want 000", disp_valid, disp_last, disp_busy); end
    vectors++; if ({gen_count, extinct, stable} !== 18'd0) begin miscompares++; $display("FAIL reset_state got gen=%0d ext=%b stab=%b want 0/0/0", gen_count, extinct, stable); end
    rst = 1'b0;
    clear_pat(z); mdl = z; mgen = 0; mext = 0; mstab = 0;
    capture(0, 1'b0, 1'b0, cap, nx, nlast, lastpos, holdbad, steps);
    bad = 0; for (int i = 0; i < N; i++) if (cap[i] != z[i]) bad++;
    vectors++; if (nx !== N || bad !== 0) begin miscompares++; $display("FAIL reset_dump got %0d xfers %0d bad bits want %0d xfers 0 bad", nx, bad, N); end
  endtask

  task automatic test_blinker();
    grid_t p, cap;
    int nx, nlast, lastpos, holdbad, steps, bad;
    clear_pat(p); p[16] = 1; p[17] = 1; p[18] = 1;
    load_grid(p);
    for (int s = 0; s < 2; s++) begin
      do_steps(1);
      capture(0, 1'b0, 1'b0, cap, nx, nlast, lastpos, holdbad, steps);
      bad = 0; for (int i = 0; i < N; i++) if (cap[i] != mdl[i]) bad++;
      vectors++; if (nx !== N || bad !== 0) begin miscompares++; $display("FAIL blinker_dump%0d got %0d xfers %0d bad bits want %0d/0", s, nx, bad, N); end
    end
    vectors++; if (gen_count !== 16'(mgen) || stable !== mstab) begin miscompares++; $display("FAIL blinker_state got gen=%0d stab=%b want gen=%0d stab=%b", gen_count, stable, mgen, mstab); end
  endtask

  task automatic test_block();
    grid_t p, cap;
    int nx, nlast, lastpos, holdbad, steps, bad;
    clear_pat(p); p[5*COLS+5] = 1; p[5*COLS+6] = 1; p[6*COLS+5] = 1; p[6*COLS+6] = 1;
    load_grid(p);
    do_steps(3);
    vectors++; if (gen_count !== 16'(mgen) || stable !== mstab || extinct !== mext) begin miscompares++; $display("FAIL block_state got gen=%0d stab=%b ext=%b want %0d/%b/%b", gen_count, stable, extinct, mgen, mstab, mext); end
    capture(1, 1'b0, 1'b0, cap, nx, nlast, lastpos, holdbad, steps);
    bad = 0; for (int i = 0; i < N; i++) if (cap[i] != p[i]) bad++;
    vectors++; if (nx !== N || bad !== 0) begin miscompares++; $display("FAIL block_dump got %0d xfers %0d bad bits want %0d/0", nx, bad, N); end
  endtask

  task automatic test_extinct_collision();
    grid_t p, cap;
    int nx, nlast, lastpos, holdbad, steps, bad;
    clear_pat(p); p[7*COLS+7] = 1;
    load_grid(p);
    do_steps(1);
    vectors++; if (extinct !== 1'b1 || gen_count !== 16'd1) begin miscompares++; $display("FAIL extinct_state got ext=%b gen=%0d want 1/1", extinct, gen_count); end
    rand_pat(p, 30);
    step = 1'b1;
    load_grid(p);
    step = 1'b0;
    vectors++; if (gen_count !== 16'd0 || extinct !== 1'b0 || stable !== 1'b0) begin miscompares++; $display("FAIL collision_state got gen=%0d ext=%b stab=%b want 0/0/0", gen_count, extinct, stable); end
    capture(0, 1'b0, 1'b0, cap, nx, nlast, lastpos, holdbad, steps);
    bad = 0; for (int i = 0; i < N; i++) if (cap[i] != p[i]) bad++;
    vectors++; if (nx !== N || bad !== 0) begin miscompares++; $display("FAIL collision_dump got %0d xfers %0d bad bits want %0d/0", nx, bad, N); end
  endtask

  task automatic test_dump_run();
    grid_t p, snap, cap;
    int nx, nlast, lastpos, holdbad, steps, bad;
    rand_pat(p, 40);
    load_grid(p);
    snap = mdl;
    capture(1, 1'b1, 1'b0, cap, nx, nlast, lastpos, holdbad, steps);
    bad = 0; for (int i = 0; i < N; i++) if (cap[i] != snap[i]) bad++;
    vectors++; if (nx !== N || bad !== 0) begin miscompares++; $display("FAIL dumprun_stream got %0d xfers %0d bad bits want %0d/0", nx, bad, N); end
    vectors++; if (nlast !== 1 || lastpos !== N - 1) begin miscompares++; $display("FAIL dumprun_last got %0d lasts at %0d want 1 at %0d", nlast, lastpos, N - 1); end
    vectors++; if (holdbad !== 0) begin miscompares++; $display("FAIL dumprun_hold got %0d unstable holds want 0", holdbad); end
    vectors++; if (disp_valid !== 1'b0 || disp_busy !== 1'b0) begin miscompares++; $display("FAIL dumprun_idle got v=%b b=%b want 0/0", disp_valid, disp_busy); end
    repeat (steps) model_step();
    vectors++; if (gen_count !== 16'(mgen) || stable !== mstab || extinct !== mext) begin miscompares++; $display("FAIL dumprun_state got gen=%0d stab=%b ext=%b want %0d/%b/%b", gen_count, stable, extinct, mgen, mstab, mext); end
    capture(0, 1'b0, 1'b0, cap, nx, nlast, lastpos, holdbad, steps);
    bad = 0; for (int i = 0; i < N; i++) if (cap[i] != mdl[i]) bad++;
    vectors++; if (nx !== N || bad !== 0) begin miscompares++; $display("FAIL dumprun_after got %0d xfers %0d bad bits want %0d/0", nx, bad, N); end
  endtask

  task automatic test_glider();
    grid_t p, cap;
    int nx, nlast, lastpos, holdbad, steps, bad;
    clear_pat(p); p[0*COLS+1] = 1; p[1*COLS+2] = 1; p[2*COLS+0] = 1; p[2*COLS+1] = 1; p[2*COLS+2] = 1;
    load_grid(p);
    run = 1'b1;
    repeat (64) @(negedge clk);
    run = 1'b0;
    repeat (64) model_step();
    vectors++; if (gen_count !== 16'd64 || stable !== mstab || extinct !== mext) begin miscompares++; $display("FAIL glider_state got gen=%0d stab=%b ext=%b want 64/%b/%b", gen_count, stable, extinct, mstab, mext); end
    capture(2, 1'b0, 1'b0, cap, nx, nlast, lastpos, holdbad, steps);
    bad = 0; for (int i = 0; i < N; i++) if (cap[i] != mdl[i]) bad++;
    vectors++; if (nx !== N || bad !== 0) begin miscompares++; $display("FAIL glider_dump got %0d xfers %0d bad bits want %0d/0", nx, bad, N); end
  endtask

  task automatic test_rst_mid_stream();
    grid_t p, z, cap;
    int nx, nlast, lastpos, holdbad, steps, bad, sent;
    rand_pat(p, 50);
    load_grid(p);
    do_steps(2);
    disp_start = 1'b1; disp_ready = 1'b1;
    @(negedge clk);
    disp_start = 1'b0;
    sent = 0;
    for (int cyc = 0; cyc < 2 * N && sent < 100; cyc++) begin
      if (disp_valid) sent++;
      @(negedge clk);
    end
    vectors++; if (sent !== 100 || disp_bit !== mdl[100] || disp_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_bit100 got sent=%0d v=%b bit=%b want 100/1/%b", sent, disp_valid, disp_bit, mdl[100]); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if ({disp_valid, disp_last, disp_busy} !== 3'b000 || gen_count !== 16'd0) begin miscompares++; $display("FAIL rstmid_abort got v/l/b=%b%b%b gen=%0d want 000/0", disp_valid, disp_last, disp_busy, gen_count); end
    rst = 1'b0; disp_ready = 1'b0;
    clear_pat(z); mdl = z; mgen = 0; mext = 0; mstab = 0;
    capture(2, 1'b0, 1'b0, cap, nx, nlast, lastpos, holdbad, steps);
    bad = 0; for (int i = 0; i < N; i++) if (cap[i] != z[i]) bad++;
    vectors++; if (nx !== N || bad !== 0 || nlast !== 1) begin miscompares++; $display("FAIL rstmid_zero_dump got %0d xfers %0d bad %0d lasts want %0d/0/1", nx, bad, nlast, N); end
  endtask

  task automatic test_random();
    grid_t p, snap, cap;
    int nx, nlast, lastpos, holdbad, steps, bad, nsteps, kind;
    bit rd;
    for (int it = 0; it < 5; it++) begin
      rand_pat(p, $urandom_range(15, 50));
      load_grid(p);
      nsteps = $urandom_range(1, 12);
      for (int s = 0; s < nsteps; s++) begin
        kind = $urandom_range(0, 3);
        en   = (kind != 3);
        step = (kind == 0);
        run  = (kind == 1) || (kind == 3);
        @(negedge clk);
        if (kind < 2) model_step();
      end
      en = 1'b1; step = 1'b0; run = 1'b0;
      vectors++; if (gen_count !== 16'(mgen) || stable !== mstab || extinct !== mext) begin miscompares++; $display("FAIL rand%0d_state got gen=%0d stab=%b ext=%b want %0d/%b/%b", it, gen_count, stable, extinct, mgen, mstab, mext); end
      snap = mdl;
      rd = 1'($urandom_range(0, 1));
      capture(2, rd, 1'b1, cap, nx, nlast, lastpos, holdbad, steps);
      bad = 0; for (int i = 0; i < N; i++) if (cap[i] != snap[i]) bad++;
      vectors++; if (nx !== N || bad !== 0 || nlast !== 1 || lastpos !== N - 1 || holdbad !== 0) begin miscompares++; $display("FAIL rand%0d_dump got xfers=%0d bad=%0d lasts=%0d at %0d holdbad=%0d want %0d/0/1/%0d/0", it, nx, bad, nlast, lastpos, holdbad, N, N - 1); end
      repeat (steps) model_step();
      vectors++; if (gen_count !== 16'(mgen) || stable !== mstab || extinct !== mext) begin miscompares++; $display("FAIL rand%0d_after got gen=%0d stab=%b ext=%b want %0d/%b/%b", it, gen_count, stable, extinct, mgen, mstab, mext); end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; load_valid = 1'b0; load_bit = 1'b0; step = 1'b0; run = 1'b0;
    disp_start = 1'b0; disp_ready = 1'b0;
    test_reset();
    test_blinker();
    test_block();
    test_extinct_collision();
    test_dump_run();
    test_glider();
    test_rst_mid_stream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
